// File: rtl/instr_register_alu.sv
// Instruction register file with a built-in signed ALU: a two-stage write pipeline
// computes the result and commits each entry, and reads return 1 cycle later with forwarding.
module instr_register_alu #(
    parameter int OP_WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int RW = 2 * OP_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [AW-1:0]              write_pointer,
    input  logic [2:0]                 opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic                       rd_en,
    input  logic [AW-1:0]              read_pointer,
    output logic                       rd_valid,
    output logic [2:0]                 rd_opcode,
    output logic signed [OP_WIDTH-1:0] rd_operand_a,
    output logic signed [OP_WIDTH-1:0] rd_operand_b,
    output logic signed [RW-1:0]       rd_result,
    output logic                       rd_div0,
    output logic                       rd_unwritten,
    output logic [AW:0]                valid_count
);

    typedef enum logic [2:0] {
        OP_ZERO  = 3'd0,
        OP_PASSA = 3'd1,
        OP_PASSB = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MULT  = 3'd5,
        OP_DIV   = 3'd6,
        OP_MOD   = 3'd7
    } opcode_e;

    logic                       s1_valid_q, s1_valid_d;
    logic [AW-1:0]              s1_addr_q, s1_addr_d;
    logic [2:0]                 s1_opcode_q, s1_opcode_d;
    logic signed [OP_WIDTH-1:0] s1_a_q, s1_a_d;
    logic signed [OP_WIDTH-1:0] s1_b_q, s1_b_d;
    logic signed [RW-1:0]       s1_result_q, s1_result_d;
    logic                       s1_div0_q, s1_div0_d;

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [AW:0]                valid_count_q, valid_count_d;

    logic                       rd_valid_q, rd_valid_d;
    logic [2:0]                 rd_opcode_q, rd_opcode_d;
    logic signed [OP_WIDTH-1:0] rd_a_q, rd_a_d;
    logic signed [OP_WIDTH-1:0] rd_b_q, rd_b_d;
    logic signed [RW-1:0]       rd_result_q, rd_result_d;
    logic                       rd_div0_q, rd_div0_d;
    logic                       rd_unwritten_q, rd_unwritten_d;

    logic [2:0]                 mem_opcode [DEPTH];
    logic signed [OP_WIDTH-1:0] mem_a      [DEPTH];
    logic signed [OP_WIDTH-1:0] mem_b      [DEPTH];
    logic signed [RW-1:0]       mem_result [DEPTH];
    logic                       mem_div0   [DEPTH];

    logic signed [RW-1:0]       a_ext, b_ext, divisor, quotient, remainder, alu_result;
    logic                       b_is_zero, alu_div0;
    logic                       fwd_hit;

    // The divisor is forced to 1 when b is zero so the divider never sees an illegal operand.
    always_comb begin
        a_ext      = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
        b_ext      = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
        b_is_zero  = (operand_b == '0);
        divisor    = b_is_zero ? {{(RW-1){1'b0}}, 1'b1} : b_ext;
        quotient   = a_ext / divisor;
        remainder  = a_ext % divisor;
        alu_result = '0;
        alu_div0   = 1'b0;
        case (opcode_e'(opcode))
            OP_ZERO:  alu_result = '0;
            OP_PASSA: alu_result = a_ext;
            OP_PASSB: alu_result = b_ext;
            OP_ADD:   alu_result = a_ext + b_ext;
            OP_SUB:   alu_result = a_ext - b_ext;
            OP_MULT:  alu_result = a_ext * b_ext;
            OP_DIV: begin
                alu_result = b_is_zero ? '0 : quotient;
                alu_div0   = b_is_zero;
            end
            OP_MOD: begin
                alu_result = b_is_zero ? '0 : remainder;
                alu_div0   = b_is_zero;
            end
            default:  alu_result = '0;
        endcase
    end

    always_comb begin
        s1_valid_d  = load_en;
        s1_addr_d   = write_pointer;
        s1_opcode_d = opcode;
        s1_a_d      = operand_a;
        s1_b_d      = operand_b;
        s1_result_d = alu_result;
        s1_div0_d   = alu_div0;

        valid_d       = valid_q;
        valid_count_d = valid_count_q;
        if (s1_valid_q) begin
            valid_d[s1_addr_q] = 1'b1;
            if (!valid_q[s1_addr_q])
                valid_count_d = valid_count_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Stage 1 holds the youngest write, so it takes priority over the array on an address match.
    always_comb begin
        fwd_hit        = s1_valid_q && (s1_addr_q == read_pointer);
        rd_valid_d     = rd_en;
        rd_opcode_d    = rd_opcode_q;
        rd_a_d         = rd_a_q;
        rd_b_d         = rd_b_q;
        rd_result_d    = rd_result_q;
        rd_div0_d      = rd_div0_q;
        rd_unwritten_d = rd_unwritten_q;
        if (rd_en) begin
            if (fwd_hit) begin
                rd_opcode_d    = s1_opcode_q;
                rd_a_d         = s1_a_q;
                rd_b_d         = s1_b_q;
                rd_result_d    = s1_result_q;
                rd_div0_d      = s1_div0_q;
                rd_unwritten_d = 1'b0;
            end else if (valid_q[read_pointer]) begin
                rd_opcode_d    = mem_opcode[read_pointer];
                rd_a_d         = mem_a[read_pointer];
                rd_b_d         = mem_b[read_pointer];
                rd_result_d    = mem_result[read_pointer];
                rd_div0_d      = mem_div0[read_pointer];
                rd_unwritten_d = 1'b0;
            end else begin
                rd_opcode_d    = '0;
                rd_a_d         = '0;
                rd_b_d         = '0;
                rd_result_d    = '0;
                rd_div0_d      = 1'b0;
                rd_unwritten_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q     <= 1'b0;
            valid_q        <= '0;
            valid_count_q  <= '0;
            rd_valid_q     <= 1'b0;
            rd_opcode_q    <= '0;
            rd_a_q         <= '0;
            rd_b_q         <= '0;
            rd_result_q    <= '0;
            rd_div0_q      <= 1'b0;
            rd_unwritten_q <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            valid_q        <= valid_d;
            valid_count_q  <= valid_count_d;
            rd_valid_q     <= rd_valid_d;
            rd_opcode_q    <= rd_opcode_d;
            rd_a_q         <= rd_a_d;
            rd_b_q         <= rd_b_d;
            rd_result_q    <= rd_result_d;
            rd_div0_q      <= rd_div0_d;
            rd_unwritten_q <= rd_unwritten_d;
        end
        s1_addr_q   <= s1_addr_d;
        s1_opcode_q <= s1_opcode_d;
        s1_a_q      <= s1_a_d;
        s1_b_q      <= s1_b_d;
        s1_result_q <= s1_result_d;
        s1_div0_q   <= s1_div0_d;
    end

    // Array contents survive reset; the valid bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (!reset && s1_valid_q) begin
            mem_opcode[s1_addr_q] <= s1_opcode_q;
            mem_a[s1_addr_q]      <= s1_a_q;
            mem_b[s1_addr_q]      <= s1_b_q;
            mem_result[s1_addr_q] <= s1_result_q;
            mem_div0[s1_addr_q]   <= s1_div0_q;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_opcode    = rd_opcode_q;
    assign rd_operand_a = rd_a_q;
    assign rd_operand_b = rd_b_q;
    assign rd_result    = rd_result_q;
    assign rd_div0      = rd_div0_q;
    assign rd_unwritten = rd_unwritten_q;
    assign valid_count  = valid_count_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// Self-checking bench for instr_register_alu: directed scenarios, a hand-computed
// vector table and a full random fill checked against a small behavioural model.
module tb_instr_register_alu;
    localparam int OP_WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW = 5;

    localparam logic [2:0] ZERO = 3'd0, PASSA = 3'd1, PASSB = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, MULT = 3'd5, DIV = 3'd6, MOD = 3'd7;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       load_en = 1'b0;
    logic [AW-1:0]              write_pointer = '0;
    logic [2:0]                 opcode = '0;
    logic signed [OP_WIDTH-1:0] operand_a = '0;
    logic signed [OP_WIDTH-1:0] operand_b = '0;
    logic                       rd_en = 1'b0;
    logic [AW-1:0]              read_pointer = '0;
    logic                       rd_valid;
    logic [2:0]                 rd_opcode;
    logic signed [OP_WIDTH-1:0] rd_operand_a;
    logic signed [OP_WIDTH-1:0] rd_operand_b;
    logic signed [2*OP_WIDTH-1:0] rd_result;
    logic                       rd_div0;
    logic                       rd_unwritten;
    logic [AW:0]                valid_count;

    int total = 0;
    int bad = 0;

    instr_register_alu #(.OP_WIDTH(OP_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .write_pointer(write_pointer),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .rd_en(rd_en), .read_pointer(read_pointer), .rd_valid(rd_valid),
        .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
        .rd_result(rd_result), .rd_div0(rd_div0), .rd_unwritten(rd_unwritten),
        .valid_count(valid_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        int         a;
        int         b;
        int         res;
        logic       div0;
    } vec_t;

    vec_t vecs [15];

    // Inputs are applied 1 time unit after an edge, and outputs are sampled at the same point.
    task automatic applyStimulus(input logic le, input int wp, input logic [2:0] op,
                                 input int a, input int b, input logic re, input int rp);
        load_en       = le;
        write_pointer = AW'(wp);
        opcode        = op;
        operand_a     = OP_WIDTH'(a);
        operand_b     = OP_WIDTH'(b);
        rd_en         = re;
        read_pointer  = AW'(rp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, ZERO, 0, 0, 1'b0, 0);
    endtask

    task automatic readAt(input int rp);
        applyStimulus(1'b0, 0, ZERO, 0, 0, 1'b1, rp);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int modelResult(input logic [2:0] op, input int a, input int b);
        case (op)
            ZERO:  return 0;
            PASSA: return a;
            PASSB: return b;
            ADD:   return a + b;
            SUB:   return a - b;
            MULT:  return a * b;
            DIV:   return (b == 0) ? 0 : a / b;
            default: return (b == 0) ? 0 : a % b;
        endcase
    endfunction

    int          ref_a   [DEPTH];
    int          ref_b   [DEPTH];
    logic [2:0]  ref_op  [DEPTH];

    initial begin
        vecs[0]  = '{ZERO,     5,    3,      0, 1'b0};
        vecs[1]  = '{PASSA, -100,    7,   -100, 1'b0};
        vecs[2]  = '{PASSB,    3, -128,   -128, 1'b0};
        vecs[3]  = '{ADD,    127,  127,    254, 1'b0};
        vecs[4]  = '{ADD,   -128, -128,   -256, 1'b0};
        vecs[5]  = '{SUB,   -128,  127,   -255, 1'b0};
        vecs[6]  = '{SUB,    100, -100,    200, 1'b0};
        vecs[7]  = '{MULT,   127, -128, -16256, 1'b0};
        vecs[8]  = '{MULT,    -1,   -1,      1, 1'b0};
        vecs[9]  = '{DIV,      7,   -2,     -3, 1'b0};
        vecs[10] = '{DIV,   -128,   -1,    128, 1'b0};
        vecs[11] = '{MOD,      7,   -2,      1, 1'b0};
        vecs[12] = '{MOD,     -7,   -2,     -1, 1'b0};
        vecs[13] = '{MOD,      5,    0,      0, 1'b1};
        vecs[14] = '{DIV,      0,    5,      0, 1'b0};

        doReset();
        checkOutput("reset rd_valid", int'(rd_valid), 0);
        checkOutput("reset valid_count", int'(valid_count), 0);
        checkOutput("reset rd_result", int'($signed(rd_result)), 0);

        // Add then read after two idle cycles, then confirm the data holds once rd_en drops.
        applyStimulus(1'b1, 3, ADD, -15, 7, 1'b0, 0);
        idle();
        idle();
        readAt(3);
        checkOutput("add rd_valid", int'(rd_valid), 1);
        checkOutput("add rd_result", int'($signed(rd_result)), -8);
        checkOutput("add rd_opcode", int'(rd_opcode), 3);
        checkOutput("add rd_div0", int'(rd_div0), 0);
        checkOutput("add valid_count", int'(valid_count), 1);
        idle();
        checkOutput("hold rd_valid", int'(rd_valid), 0);
        checkOutput("hold rd_result", int'($signed(rd_result)), -8);

        // Forwarded DIV; a same-edge MOD write must not be visible until the next read.
        applyStimulus(1'b1, 5, DIV, -7, 2, 1'b0, 0);
        applyStimulus(1'b1, 5, MOD, -7, 2, 1'b1, 5);
        checkOutput("fwd div rd_result", int'($signed(rd_result)), -3);
        checkOutput("fwd div rd_opcode", int'(rd_opcode), 6);
        readAt(5);
        checkOutput("fwd mod rd_result", int'($signed(rd_result)), -1);
        checkOutput("fwd mod rd_opcode", int'(rd_opcode), 7);
        checkOutput("rewrite valid_count", int'(valid_count), 2);

        // Divide by zero and an unwritten address.
        applyStimulus(1'b1, 9, DIV, 12, 0, 1'b0, 0);
        idle();
        readAt(9);
        checkOutput("div0 rd_result", int'($signed(rd_result)), 0);
        checkOutput("div0 rd_div0", int'(rd_div0), 1);
        checkOutput("div0 rd_unwritten", int'(rd_unwritten), 0);
        readAt(10);
        checkOutput("unwritten flag", int'(rd_unwritten), 1);
        checkOutput("unwritten rd_opcode", int'(rd_opcode), 0);
        checkOutput("unwritten rd_operand_a", int'(rd_operand_a), 0);
        checkOutput("unwritten rd_operand_b", int'(rd_operand_b), 0);
        checkOutput("unwritten rd_result", int'($signed(rd_result)), 0);
        checkOutput("unwritten rd_div0", int'(rd_div0), 0);
        checkOutput("three writes valid_count", int'(valid_count), 3);

        // Back-to-back writes to one address: reads must see the youngest.
        doReset();
        applyStimulus(1'b1, 2, MULT, -128, -128, 1'b0, 0);
        applyStimulus(1'b1, 2, PASSB, 9, 4, 1'b1, 2);
        checkOutput("mult rd_result", int'($signed(rd_result)), 16384);
        readAt(2);
        checkOutput("passb rd_result", int'($signed(rd_result)), 4);
        checkOutput("passb rd_operand_a", int'(rd_operand_a), 9);
        checkOutput("passb valid_count", int'(valid_count), 1);

        // Reset one edge after a write drops it; load_en and rd_en during reset are ignored.
        applyStimulus(1'b1, 7, ADD, 1, 2, 1'b0, 0);
        reset = 1'b1;
        applyStimulus(1'b1, 8, PASSA, 5, 5, 1'b1, 2);
        reset = 1'b0;
        checkOutput("in reset rd_valid", int'(rd_valid), 0);
        checkOutput("in reset rd_result", int'($signed(rd_result)), 0);
        checkOutput("in reset rd_operand_a", int'(rd_operand_a), 0);
        checkOutput("in reset valid_count", int'(valid_count), 0);
        readAt(7);
        checkOutput("flushed addr7 unwritten", int'(rd_unwritten), 1);
        readAt(8);
        checkOutput("ignored addr8 unwritten", int'(rd_unwritten), 1);
        checkOutput("after flush valid_count", int'(valid_count), 0);

        // Hand-computed vector table written back-to-back, then read back.
        doReset();
        for (int i = 0; i < 15; i++)
            applyStimulus(1'b1, i, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 0);
        idle();
        for (int i = 0; i < 15; i++) begin
            readAt(i);
            checkOutput($sformatf("vec%0d rd_result", i), int'($signed(rd_result)), vecs[i].res);
            checkOutput($sformatf("vec%0d rd_div0", i), int'(rd_div0), int'(vecs[i].div0));
            checkOutput($sformatf("vec%0d rd_opcode", i), int'(rd_opcode), int'(vecs[i].op));
        end
        checkOutput("table valid_count", int'(valid_count), 15);

        // Random fill of every entry, starting at DEPTH-1 and wrapping to 0.
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            int addr;
            addr = (i + DEPTH - 1) % DEPTH;
            ref_op[addr] = 3'($urandom_range(0, 7));
            ref_a[addr]  = int'($urandom_range(0, 255)) - 128;
            ref_b[addr]  = (i % 8 == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            applyStimulus(1'b1, addr, ref_op[addr], ref_a[addr], ref_b[addr], 1'b0, 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic exp_div0;
            readAt(i);
            exp_div0 = (ref_op[i] == DIV || ref_op[i] == MOD) && ref_b[i] == 0;
            checkOutput($sformatf("rand%0d rd_result", i), int'($signed(rd_result)),
                        modelResult(ref_op[i], ref_a[i], ref_b[i]));
            checkOutput($sformatf("rand%0d rd_div0", i), int'(rd_div0), int'(exp_div0));
            checkOutput($sformatf("rand%0d rd_operand_a", i), int'(rd_operand_a), ref_a[i]);
            checkOutput($sformatf("rand%0d rd_operand_b", i), int'(rd_operand_b), ref_b[i]);
            checkOutput($sformatf("rand%0d rd_unwritten", i), int'(rd_unwritten), 0);
        end
        checkOutput("full valid_count", int'(valid_count), DEPTH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_register_alu.md
INSTR_REGISTER_ALU -- requirements
Module: instr_register_alu

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 8, meaning operand width in bits (two's complement signed, legal 2..16).
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of entries (power of 2, legal 2..256); AW = log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, meaning the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port load_en, input, 1, meaning a write request sampled at a clk edge.
REQ-006 SHALL have port write_pointer, input, AW, meaning the write address.
REQ-007 SHALL have port opcode, input, 3, meaning the operation: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
REQ-008 SHALL have ports operand_a and operand_b, input, OP_WIDTH each, meaning signed operands.
REQ-009 SHALL have port rd_en, input, 1, meaning a read request.
REQ-010 SHALL have port read_pointer, input, AW, meaning the read address.
REQ-011 SHALL have port rd_valid, output, 1, meaning the read data is valid.
REQ-012 SHALL have ports rd_opcode (3), rd_operand_a (OP_WIDTH), rd_operand_b (OP_WIDTH) and rd_result (2*OP_WIDTH, signed), all outputs, meaning the stored entry.
REQ-013 SHALL have port rd_div0, output, 1, meaning the entry was a DIV or MOD with operand_b=0.
REQ-014 SHALL have port rd_unwritten, output, 1, meaning the addressed entry has not been written since reset.
REQ-015 SHALL have port valid_count, output, AW+1, meaning the number of entries written since reset.

Function
REQ-016 SHALL use a 2-stage write pipeline: load_en at edge t captures the request into stage 1, and at edge t+1 the entry (opcode, operands, result, div0 flag) is written to the array and its valid bit is set.
REQ-017 SHALL accept a write every cycle with no back-pressure (throughput 1 per cycle).
REQ-018 SHALL compute all arithmetic signed at 2*OP_WIDTH after sign extension: ZERO gives 0; PASSA gives a; PASSB gives b; ADD gives a+b; SUB gives a-b; MULT gives a*b (full width, no overflow).
REQ-019 SHALL compute DIV as truncation toward zero and MOD as a remainder whose sign follows the dividend.
REQ-020 SHALL set result=0 and div0=1 for DIV or MOD with b=0; div0=0 for every other case.
REQ-021 SHALL give reads 1-cycle latency: rd_en at edge r drives rd_valid=1 and the data after edge r; rd_valid=0 after any edge without rd_en.
REQ-022 SHALL hold all rd_* data outputs at their last value when rd_valid=0.
REQ-023 SHALL ensure a read at edge r returns the effect of every write accepted at edges before r, forwarding from stage 1 when that stage holds the same address (read-after-write hazard).
REQ-024 SHALL ensure a write accepted at the same edge r is not visible to the read at r.
REQ-025 SHALL resolve back-to-back writes to the same address last-writer-wins, and forwarding SHALL return the youngest of them.
REQ-026 SHALL, on a read of an unwritten entry, output rd_unwritten=1, all data fields 0 and rd_div0=0.
REQ-027 SHALL increment valid_count only when a valid bit goes 0 to 1; rewriting an entry SHALL NOT increment it; the maximum value is DEPTH.
REQ-028 SHALL wrap no addresses: pointers are exactly AW bits, and an address of DEPTH-1 followed by 0 is ordinary.

Reset
REQ-029 SHALL, when reset=1 at an edge, clear all valid bits, flush stage 1 (the pending write is dropped), and set rd_valid=0, valid_count=0 and all rd_* outputs to 0.
REQ-030 SHALL ignore load_en and rd_en in any cycle where reset=1; array data contents need not be cleared.
REQ-031 SHALL accept load_en and rd_en at the first edge after reset deasserts.

Verification
REQ-032 SHALL be verified by this scenario: reset, then write addr 3 ADD a=-15 b=7, idle 2 cycles, read 3 -> rd_result=-8, rd_opcode=3, rd_div0=0, valid_count=1.
REQ-033 SHALL be verified by this scenario: write addr 5 DIV a=-7 b=2, then read 5 at the very next edge -> forwarded rd_result=-3; MOD with the same operands -> rd_result=-1.
REQ-034 SHALL be verified by this scenario: write addr 9 DIV a=12 b=0 -> rd_result=0, rd_div0=1; read never-written addr 10 -> rd_unwritten=1 and all data fields 0.
REQ-035 SHALL be verified by this scenario: write addr 2 MULT a=-128 b=-128 (OP_WIDTH=8) -> rd_result=16384; write addr 2 PASSB b=4 next cycle, read at the following edge -> 4, valid_count=1.
REQ-036 SHALL be verified by this scenario: write addr 7 at edge t, reset=1 at edge t+1, read 7 after reset -> rd_unwritten=1, valid_count=0.
REQ-037 SHALL be verified by this scenario: fill all DEPTH entries with random ops, then read all -> each matches a reference model and valid_count=DEPTH.
